dc_req_queue: RTL and testbench
===============================

DC_REQ_QUEUE -- requirements
Module: dc_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2 or more.
REQ-002 Parameter ADDR_WIDTH, default 32, request address width.
REQ-003 Parameter DATA_WIDTH, default 32, request data width.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 flush  in  1  recovery flush from the hazard controller; discards all queued state.
REQ-007 in_valid  in  1  request from the hazard controller D-cache request port.
REQ-008 in_ready  out  1  queue can accept the request this cycle.
REQ-009 in_write  in  1  request type: 1 = store (WRITE), 0 = load (READ).
REQ-010 in_addr  in  ADDR_WIDTH  request address.
REQ-011 in_data  in  DATA_WIDTH  store data; ignored for loads.
REQ-012 out_valid  out  1  head request presented to the D-cache.
REQ-013 out_ready  in  1  D-cache accepts the head request.
REQ-014 out_write / out_addr / out_data  out  1 / ADDR_WIDTH / DATA_WIDTH  head request fields.
REQ-015 fwd_valid  out  1  load satisfied from a queued store.
REQ-016 fwd_data  out  DATA_WIDTH  forwarded load value.
REQ-017 count  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Storage: circular buffer of DEPTH entries {write, addr, data}, with head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-019 in_ready = (count < DEPTH) and not flush; combinational, with no dependence on out_ready (no pass-through when full).
REQ-020 Accept condition: in_valid and in_ready.
REQ-021 Accepted store: written at tail; tail increments.
REQ-022 Accepted load, no queued store with equal addr: enqueued like a store.
REQ-023 Accepted load with one or more queued stores at equal addr: not enqueued; the next cycle has fwd_valid=1 and fwd_data = data of the youngest matching store (nearest to tail). fwd_valid is a one-cycle pulse.
REQ-024 Match compare: full ADDR_WIDTH equality over occupied entries only; an entry dequeuing in the same cycle still counts as occupied.
REQ-025 Dequeue: out_valid = (count != 0); out_* = head entry; on out_valid and out_ready, head increments.
REQ-026 Latency: a request accepted into an empty queue appears on out_valid the next cycle; there is no same-cycle bypass.
REQ-027 Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
REQ-028 Full (count == DEPTH): in_ready=0; a dequeue that cycle does not enable an enqueue until the following cycle.
REQ-029 Empty: out_valid=0; out_ready is ignored.
REQ-030 Request order to the D-cache: strictly FIFO; a load is never reordered around a store.
REQ-031 Flush: on the next edge, head=tail=0, count=0, fwd_valid=0; nothing is accepted during the flush cycle, and a dequeue handshake in the flush cycle is discarded.
REQ-032 out_* fields hold stable while out_valid=1 and out_ready=0.

Reset
REQ-033 rst=1 SHALL immediately force head=0, tail=0, count=0, out_valid=0, fwd_valid=0, fwd_data=0.
REQ-034 in_ready SHALL be 1 from the first cycle after rst deasserts, given flush=0.
REQ-035 Entry contents are not reset; reset mid-operation drops all entries and any pending forward.

Verification
REQ-036 Fill: 4 stores to addr 0x10,0x14,0x18,0x1C with out_ready=0 -> count=4, in_ready=0; out_addr=0x10 stable.
REQ-037 Forward: store 0x20/0xAAAA, then store 0x20/0xBBBB, then load 0x20, all with out_ready=0 -> next cycle fwd_valid=1, fwd_data=0xBBBB; count stays 2.
REQ-038 Wrap: enqueue and dequeue continuously for 10 requests on DEPTH=4 -> output order equals input order; count never exceeds 4.
REQ-039 Full plus dequeue: at count=4, out_ready=1 and in_valid=1 -> no accept that cycle, count=3; next cycle the request is accepted.
REQ-040 Flush: count=3, flush=1 with in_valid=1 -> in_ready=0; next cycle count=0, out_valid=0.
REQ-041 Async reset: assert rst mid-cycle while count=2 -> out_valid=0 and count=0 before the next clock edge.

Source files
------------

// File: rtl/dc_req_queue.sv
// D-cache request queue: FIFO of load/store requests with store-to-load
// forwarding from the youngest queued store at a matching address.
module dc_req_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_write,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_write,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    fwd_valid,
    output logic [DATA_WIDTH-1:0]   fwd_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                  r_write [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data  [DEPTH];

    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_fwdValid;
    logic [DATA_WIDTH-1:0] r_fwdData;

    logic                  w_accept;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_fwd;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] w_matchData;
    logic [PW-1:0]         w_idx;

    assign in_ready  = (r_count < CW'(DEPTH)) && !flush;
    assign out_valid = (r_count != '0);
    assign out_write = r_write[r_head];
    assign out_addr  = r_addr[r_head];
    assign out_data  = r_data[r_head];
    assign fwd_valid = r_fwdValid;
    assign fwd_data  = r_fwdData;
    assign count     = r_count;

    assign w_accept = in_valid && in_ready;
    assign w_fwd    = w_accept && !in_write && w_match;
    assign w_enq    = w_accept && !w_fwd;
    assign w_deq    = out_valid && out_ready;

    // Scan oldest to youngest so the last hit is the store nearest the tail.
    always_comb begin
        w_match     = 1'b0;
        w_matchData = '0;
        w_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && r_write[w_idx] && (r_addr[w_idx] == in_addr)) begin
                w_match     = 1'b1;
                w_matchData = r_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_write[r_tail] <= in_write;
            r_addr[r_tail]  <= in_addr;
            r_data[r_tail]  <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fwdValid <= 1'b0;
            r_fwdData  <= '0;
        end else if (flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fwdValid <= 1'b0;
        end else begin
            r_fwdValid <= w_fwd;
            if (w_fwd)
                r_fwdData <= w_matchData;
            if (w_enq)
                r_tail <= r_tail + 1'b1;
            if (w_deq)
                r_head <= r_head + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_req_queue.sv
// Directed self-checking bench for dc_req_queue (DEPTH=4, 32-bit fields).
module tb_dc_req_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_write;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_write;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    int nCompared = 0;
    int nFailed   = 0;

    dc_req_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_write  (in_write),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_write (out_write),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .fwd_valid (fwd_valid),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        in_valid = v;
        in_write = w;
        in_addr  = a;
        in_data  = d;
    endtask

    int          rdIdx;
    logic [31:0] fillAddr [4];

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        fillAddr[0] = 32'h10; fillAddr[1] = 32'h14;
        fillAddr[2] = 32'h18; fillAddr[3] = 32'h1C;

        // Reset state
        #3;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_fwd_valid", fwd_valid, 0);
        checkOutput("rst_fwd_data", fwd_data, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_out_valid", out_valid, 0);

        // Fill with four stores, D-cache stalled
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, fillAddr[k], 32'h100 + k);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("fill_count", count, 4);
        checkOutput("fill_in_ready", in_ready, 0);
        checkOutput("fill_out_valid", out_valid, 1);
        checkOutput("fill_out_addr", out_addr, 32'h10);
        tick();
        tick();
        checkOutput("fill_out_addr_stable", out_addr, 32'h10);
        checkOutput("fill_out_data_stable", out_data, 32'h100);

        // Full plus dequeue: no accept in the dequeue cycle
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h30, 32'h5);
        #1;
        checkOutput("full_in_ready", in_ready, 0);
        tick();
        checkOutput("full_deq_count", count, 3);
        checkOutput("full_deq_head", out_addr, 32'h14);
        out_ready = 1'b0;
        #1;
        checkOutput("after_full_in_ready", in_ready, 1);
        tick();
        checkOutput("after_full_count", count, 4);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Dequeue one, then flush with a request and a handshake present
        out_ready = 1'b1;
        tick();
        checkOutput("pre_flush_count", count, 3);
        checkOutput("pre_flush_head", out_addr, 32'h18);
        flush = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h6);
        #1;
        checkOutput("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("flush_count", count, 0);
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_fwd_valid", fwd_valid, 0);

        // Forward from the youngest matching store
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hAAAA);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hBBBB);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("fwd_valid", fwd_valid, 1);
        checkOutput("fwd_data", fwd_data, 32'hBBBB);
        checkOutput("fwd_count", count, 2);
        checkOutput("fwd_head_addr", out_addr, 32'h20);
        checkOutput("fwd_head_data", out_data, 32'hAAAA);
        tick();
        checkOutput("fwd_pulse_end", fwd_valid, 0);
        checkOutput("fwd_count_hold", count, 2);

        // Asynchronous reset mid-cycle with two entries queued
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_count", count, 0);
        checkOutput("arst_fwd_data", fwd_data, 0);
        #1 rst = 1'b0;
        tick();
        checkOutput("arst_in_ready", in_ready, 1);

        // Wrap: ten requests streamed with continuous dequeue
        rdIdx = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k < 10)
                applyStimulus(1'b1, k[0] == 1'b0, 32'h100 + 32'(4 * k), 32'h900 + 32'(k));
            else
                applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            if (count > 3'd4) begin
                checkOutput("wrap_count_bound", count, 4);
            end
            if (out_valid && rdIdx < 10) begin
                checkOutput("wrap_addr", out_addr, 32'h100 + 32'(4 * rdIdx));
                checkOutput("wrap_write", out_write, (rdIdx % 2) == 0);
                rdIdx++;
            end
            tick();
        end
        checkOutput("wrap_drained", rdIdx, 10);
        checkOutput("wrap_end_count", count, 0);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
